// File: rtl/maple_frame_parser.sv
// Maple Bus frame parser: splits the receiver byte stream into header fields,
// forwarded payload bytes and a per-frame CRC/length status. Malformed frames
// are flushed up to their TLAST so the next frame always starts aligned.
module maple_frame_parser #(
  parameter int unsigned MAX_WORDS = 255
) (
  input  logic       S_AXIS_ACLK,
  input  logic       S_AXIS_ARESETN,
  input  logic       S_AXIS_TVALID,
  input  logic [7:0] S_AXIS_TDATA,
  input  logic       S_AXIS_TLAST,
  output logic       S_AXIS_TREADY,
  output logic       M_AXIS_TVALID,
  output logic [7:0] M_AXIS_TDATA,
  output logic       M_AXIS_TLAST,
  input  logic       M_AXIS_TREADY,
  output logic [7:0] HDR_LEN,
  output logic [7:0] HDR_SRC,
  output logic [7:0] HDR_DST,
  output logic [7:0] HDR_CMD,
  output logic       HDR_VALID,
  output logic       STATUS_VALID,
  output logic       CRC_ERROR,
  output logic       LEN_ERROR
);

  typedef enum logic [1:0] {
    ST_HDR,
    ST_PAYLOAD,
    ST_CRC,
    ST_DRAIN
  } state_t;

  state_t      state;
  logic [1:0]  hdr_idx;
  logic [9:0]  byte_cnt;
  logic [7:0]  crc_acc;
  logic        crc_pend;
  logic        len_pend;

  logic        beat;
  logic [9:0]  last_idx;
  logic        payload_last;
  logic        len_too_big;
  logic        crc_bad;

  // Only the payload path can stall: the single output register must be free
  // or draining this cycle before another payload byte is taken.
  assign S_AXIS_TREADY = (state == ST_PAYLOAD) ? (M_AXIS_TREADY || !M_AXIS_TVALID) : 1'b1;
  assign beat          = S_AXIS_TVALID && S_AXIS_TREADY;
  assign last_idx      = {HDR_LEN, 2'b00} - 10'd1;
  assign payload_last  = (byte_cnt == last_idx);
  assign len_too_big   = ({24'd0, HDR_LEN} > MAX_WORDS);
  assign crc_bad       = (S_AXIS_TDATA != crc_acc);

  // Frame FSM, header capture, CRC accumulation, payload output register and status.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state         <= ST_HDR;
      hdr_idx       <= 2'd0;
      byte_cnt      <= 10'd0;
      crc_acc       <= 8'd0;
      crc_pend      <= 1'b0;
      len_pend      <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= 8'd0;
      M_AXIS_TLAST  <= 1'b0;
      HDR_LEN       <= 8'd0;
      HDR_SRC       <= 8'd0;
      HDR_DST       <= 8'd0;
      HDR_CMD       <= 8'd0;
      HDR_VALID     <= 1'b0;
      STATUS_VALID  <= 1'b0;
      CRC_ERROR     <= 1'b0;
      LEN_ERROR     <= 1'b0;
    end else begin
      HDR_VALID    <= 1'b0;
      STATUS_VALID <= 1'b0;

      // The output register empties on its own handshake, whatever the state.
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        M_AXIS_TVALID <= 1'b0;
      end

      if (beat) begin
        case (state)
          ST_HDR: begin
            crc_acc <= crc_acc ^ S_AXIS_TDATA;
            case (hdr_idx)
              2'd0:    HDR_LEN <= S_AXIS_TDATA;
              2'd1:    HDR_SRC <= S_AXIS_TDATA;
              2'd2:    HDR_DST <= S_AXIS_TDATA;
              default: HDR_CMD <= S_AXIS_TDATA;
            endcase
            if (S_AXIS_TLAST) begin
              // Truncated header: report framing error, stay aligned for next frame.
              hdr_idx      <= 2'd0;
              crc_acc      <= 8'd0;
              STATUS_VALID <= 1'b1;
              CRC_ERROR    <= 1'b0;
              LEN_ERROR    <= 1'b1;
            end else if (hdr_idx == 2'd3) begin
              hdr_idx   <= 2'd0;
              HDR_VALID <= 1'b1;
              byte_cnt  <= 10'd0;
              if (HDR_LEN == 8'd0) begin
                state <= ST_CRC;
              end else if (len_too_big) begin
                state    <= ST_DRAIN;
                len_pend <= 1'b1;
                crc_pend <= 1'b0;
              end else begin
                state <= ST_PAYLOAD;
              end
            end else begin
              hdr_idx <= hdr_idx + 2'd1;
            end
          end

          ST_PAYLOAD: begin
            crc_acc       <= crc_acc ^ S_AXIS_TDATA;
            byte_cnt      <= byte_cnt + 10'd1;
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= S_AXIS_TDATA;
            M_AXIS_TLAST  <= S_AXIS_TLAST || payload_last;
            if (S_AXIS_TLAST) begin
              // Frame ended early or without its CRC byte.
              state        <= ST_HDR;
              crc_acc      <= 8'd0;
              STATUS_VALID <= 1'b1;
              CRC_ERROR    <= 1'b0;
              LEN_ERROR    <= 1'b1;
            end else if (payload_last) begin
              state <= ST_CRC;
            end
          end

          ST_CRC: begin
            if (S_AXIS_TLAST) begin
              state        <= ST_HDR;
              crc_acc      <= 8'd0;
              STATUS_VALID <= 1'b1;
              CRC_ERROR    <= crc_bad;
              LEN_ERROR    <= 1'b0;
            end else begin
              // Extra bytes after the CRC: remember the CRC verdict, flush the rest.
              state    <= ST_DRAIN;
              crc_pend <= crc_bad;
              len_pend <= 1'b1;
            end
          end

          default: begin
            if (S_AXIS_TLAST) begin
              state        <= ST_HDR;
              crc_acc      <= 8'd0;
              STATUS_VALID <= 1'b1;
              CRC_ERROR    <= crc_pend;
              LEN_ERROR    <= len_pend;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_maple_frame_parser.sv
// Directed bench for maple_frame_parser: drives whole frames, collects header,
// payload and status transactions on the falling edge and compares them with
// hand-computed expectations.
module tb_maple_frame_parser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_tvalid;
  logic [7:0] s_tdata;
  logic       s_tlast;
  logic       s_tready;
  logic       m_tvalid;
  logic [7:0] m_tdata;
  logic       m_tlast;
  logic       m_tready;
  logic [7:0] hdr_len, hdr_src, hdr_dst, hdr_cmd;
  logic       hdr_valid, status_valid, crc_error, len_error;

  always #5 clk = ~clk;

  maple_frame_parser #(.MAX_WORDS(255)) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TREADY (s_tready),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TREADY (m_tready),
    .HDR_LEN       (hdr_len),
    .HDR_SRC       (hdr_src),
    .HDR_DST       (hdr_dst),
    .HDR_CMD       (hdr_cmd),
    .HDR_VALID     (hdr_valid),
    .STATUS_VALID  (status_valid),
    .CRC_ERROR     (crc_error),
    .LEN_ERROR     (len_error)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  exp_data_q[$];
  logic        exp_last_q[$];
  logic [7:0]  rx_data_q[$];
  logic        rx_last_q[$];
  logic [31:0] hdr_q[$];
  logic [1:0]  stat_q[$];

  logic       bp_en = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int         bp_idx = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Downstream ready: always 1 unless the 1,0,0,1 backpressure pattern is enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        m_tready = bp_pat[bp_idx % 4];
        bp_idx++;
      end
    end
  end

  // Monitor: record completed transfers and check output hold / input stall rules.
  initial begin
    logic       prev_stalled;
    logic [7:0] prev_data;
    prev_stalled = 1'b0;
    prev_data    = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stalled = 1'b0;
      end else begin
        if (prev_stalled) begin
          check("hold_valid", {31'd0, m_tvalid}, 32'd1);
          check("hold_data", {24'd0, m_tdata}, {24'd0, prev_data});
        end
        if (!s_tready) begin
          check("stall_reason", {31'd0, m_tvalid && !m_tready}, 32'd1);
        end
        if (m_tvalid && m_tready) begin
          rx_data_q.push_back(m_tdata);
          rx_last_q.push_back(m_tlast);
        end
        if (hdr_valid) hdr_q.push_back({hdr_len, hdr_src, hdr_dst, hdr_cmd});
        if (status_valid) stat_q.push_back({crc_error, len_error});
        prev_stalled = m_tvalid && !m_tready;
        prev_data    = m_tdata;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_tready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check("send_timeout", {31'd0, s_tready}, 32'd1);
  endtask

  task automatic send_frame();
    for (int i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i], i == tx_q.size() - 1);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    tx_q.delete();
  endtask

  task automatic clear_obs();
    rx_data_q.delete();
    rx_last_q.delete();
    hdr_q.delete();
    stat_q.delete();
  endtask

  task automatic expect_frame(input string tag, input int n_hdr, input logic [31:0] hdr_exp,
                              input logic [1:0] stat_exp);
    int n;
    repeat (6) @(posedge clk);
    #2;
    check({tag, "_hdr_cnt"}, hdr_q.size(), n_hdr);
    if (n_hdr > 0 && hdr_q.size() > 0) check({tag, "_hdr"}, hdr_q[0], hdr_exp);
    check({tag, "_pay_cnt"}, rx_data_q.size(), exp_data_q.size());
    n = (rx_data_q.size() < exp_data_q.size()) ? rx_data_q.size() : exp_data_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), {24'd0, rx_data_q[i]}, {24'd0, exp_data_q[i]});
      check($sformatf("%s_last%0d", tag, i), {31'd0, rx_last_q[i]}, {31'd0, exp_last_q[i]});
    end
    check({tag, "_stat_cnt"}, stat_q.size(), 1);
    if (stat_q.size() > 0) check({tag, "_stat"}, {30'd0, stat_q[0]}, {30'd0, stat_exp});
    $display("frame %s: hdrs=%0d payload=%0d status=%0d crc/len=%b errors_so_far=%0d",
             tag, hdr_q.size(), rx_data_q.size(), stat_q.size(),
             (stat_q.size() > 0) ? stat_q[0] : 2'b00, n_errors);
    clear_obs();
    exp_data_q.delete();
    exp_last_q.delete();
  endtask

  task automatic load_nominal(input logic [7:0] crc);
    tx_q = '{8'h01, 8'h00, 8'h20, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    tx_q.push_back(crc);
    exp_data_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    exp_last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'd0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_hdr_valid", {31'd0, hdr_valid}, 32'd0);
    check("rst_status_valid", {31'd0, status_valid}, 32'd0);
    check("rst_hdr", {hdr_len, hdr_src, hdr_dst, hdr_cmd}, 32'd0);
    check("rst_errors", {30'd0, crc_error, len_error}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_s_tready", {31'd0, s_tready}, 32'd1);
    $display("reset: checks=%0d errors=%0d", n_checks, n_errors);

    // Nominal frame
    load_nominal(8'h20);
    send_frame();
    expect_frame("nominal", 1, 32'h01002001, 2'b00);

    // Bad CRC
    load_nominal(8'h21);
    send_frame();
    expect_frame("bad_crc", 1, 32'h01002001, 2'b10);
    check("bad_crc_held", {31'd0, crc_error}, 32'd1);

    // Backpressure 1,0,0,1
    bp_idx = 0;
    bp_en  = 1'b1;
    load_nominal(8'h20);
    send_frame();
    expect_frame("backpressure", 1, 32'h01002001, 2'b00);
    bp_en = 1'b0;
    @(posedge clk);
    #1;
    m_tready = 1'b1;

    // Short frame, then a clean nominal frame
    tx_q = '{8'h01, 8'h00, 8'h20, 8'h01, 8'hAA, 8'hBB};
    exp_data_q = '{8'hAA, 8'hBB};
    exp_last_q = '{1'b0, 1'b1};
    send_frame();
    expect_frame("short", 1, 32'h01002001, 2'b01);
    load_nominal(8'h20);
    send_frame();
    expect_frame("after_short", 1, 32'h01002001, 2'b00);

    // Zero length with trailing byte after a matching CRC
    tx_q = '{8'h00, 8'h00, 8'h20, 8'h05, 8'h25, 8'h33};
    send_frame();
    expect_frame("zero_len", 1, 32'h00002005, 2'b01);

    // Header cut short by TLAST: no header pulse, length error
    tx_q = '{8'h02, 8'h11};
    send_frame();
    expect_frame("trunc_hdr", 0, 32'h0, 2'b01);

    // Asynchronous reset mid-payload
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    s_tvalid = 1'b0;
    check("mid_tvalid_before", {31'd0, m_tvalid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("mid_rst_status", {31'd0, status_valid}, 32'd0);
    check("mid_rst_hdr_valid", {31'd0, hdr_valid}, 32'd0);
    check("mid_rst_hdr_len", {24'd0, hdr_len}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_obs();
    $display("reset mid-payload: errors_so_far=%0d", n_errors);
    load_nominal(8'h20);
    send_frame();
    expect_frame("after_reset", 1, 32'h01002001, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
